// File: rtl/mux4_arbiter.sv
// Purpose: round-robin (or fixed-priority with MUX4_ARB_FIXED_PRIO_EN) arbiter driving a 4:1 WIDTH-bit mux.
// Latency: req -> gnt 1 cycle; transfer edge -> dout/dout_valid 1 cycle; 1 word/cycle while owner holds req.
// Backpressure: none; a word moves on every edge with gnt[i]&req[i], owner may be preempted after HOLD_MAX words.
module mux4_arbiter #(
  parameter int WIDTH    = 8,
  parameter int HOLD_MAX = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       req,
  input  logic [WIDTH-1:0] Ain,
  input  logic [WIDTH-1:0] Bin,
  input  logic [WIDTH-1:0] Cin,
  input  logic [WIDTH-1:0] Din,
  output logic [3:0]       gnt,
  output logic [1:0]       reg_sel,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  output logic             busy
);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t           state, state_nxt;
  logic [3:0]       gnt_nxt;
  logic [1:0]       sel_nxt;
  logic             xfer;
  logic [3:0]       others;
  logic             grant_new;
  logic [1:0]       new_idx;
  logic [WIDTH-1:0] mux_dat;

`ifdef MUX4_ARB_FIXED_PRIO_EN
  logic [3:0]       higher;
`else
  localparam int HW = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_MAX - 1);

  logic [1:0]       rr_ptr, rr_nxt;
  logic [HW-1:0]    hold_cnt, hold_nxt;

  // First set bit of r at or above start, wrapping modulo 4.
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] start);
    logic [1:0] idx;
    rr_pick = start;
    for (int k = 3; k >= 0; k--) begin
      idx = start + 2'(k);
      if (r[idx]) rr_pick = idx;
    end
  endfunction
`endif

  // Lowest set index of r (A has highest priority).
  function automatic logic [1:0] low_pick(input logic [3:0] r);
    low_pick = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (r[k]) low_pick = 2'(k);
    end
  endfunction

  // A word moves whenever the granted requester is still requesting.
  assign xfer   = (state == GRANT) && req[reg_sel];
  // Contenders other than the current owner; in IDLE gnt is zero so this is all of req.
  assign others = req & ~gnt;
  assign busy   = |gnt;

  // Shared 4:1 data mux steered by the registered select.
  always_comb begin
    mux_dat = Ain;
    case (reg_sel)
      2'd0:    mux_dat = Ain;
      2'd1:    mux_dat = Bin;
      2'd2:    mux_dat = Cin;
      default: mux_dat = Din;
    endcase
  end

  // Next owner, state and bookkeeping.
  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt;
    sel_nxt   = reg_sel;
    grant_new = 1'b0;
`ifdef MUX4_ARB_FIXED_PRIO_EN
    new_idx   = low_pick(others);
    higher    = req & ((4'b0001 << reg_sel) - 4'b0001);
`else
    new_idx   = rr_pick(others, rr_ptr);
    rr_nxt    = rr_ptr;
    hold_nxt  = hold_cnt;
`endif
    case (state)
      IDLE: begin
        if (|req) grant_new = 1'b1;
      end
      default: begin
        if (!req[reg_sel]) begin
          // Owner released: hand over without a bubble, or go idle.
          if (|others) begin
            grant_new = 1'b1;
          end else begin
            state_nxt = IDLE;
            gnt_nxt   = 4'b0000;
          end
        end else begin
`ifdef MUX4_ARB_FIXED_PRIO_EN
          // Only a higher-priority requester may take over on a transfer.
          if (|higher) begin
            grant_new = 1'b1;
            new_idx   = low_pick(higher);
          end
`else
          if ((hold_cnt == HOLD_LAST) && (|others)) begin
            grant_new = 1'b1;
          end else if (hold_cnt != HOLD_LAST) begin
            hold_nxt = hold_cnt + 1'b1;
          end
`endif
        end
      end
    endcase
    if (grant_new) begin
      state_nxt = GRANT;
      gnt_nxt   = 4'b0001 << new_idx;
      sel_nxt   = new_idx;
`ifndef MUX4_ARB_FIXED_PRIO_EN
      rr_nxt    = new_idx + 2'd1;
      hold_nxt  = '0;
`endif
    end
  end

  // Arbitration state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      gnt     <= 4'b0000;
      reg_sel <= 2'd0;
`ifndef MUX4_ARB_FIXED_PRIO_EN
      rr_ptr   <= 2'd0;
      hold_cnt <= '0;
`endif
    end else begin
      state   <= state_nxt;
      gnt     <= gnt_nxt;
      reg_sel <= sel_nxt;
`ifndef MUX4_ARB_FIXED_PRIO_EN
      rr_ptr   <= rr_nxt;
      hold_cnt <= hold_nxt;
`endif
    end
  end

  // Output word register: capture on transfer, otherwise hold and drop the strobe.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dout       <= '0;
      dout_valid <= 1'b0;
    end else begin
      dout_valid <= xfer;
      if (xfer) dout <= mux_dat;
    end
  end

endmodule

// File: tb/tb_mux4_arbiter.sv
// Purpose: randomized + directed scoreboard bench for mux4_arbiter against a behavioural owner/queue model.
// Latency: expects gnt one edge after selection and dout/dout_valid one edge after each transfer.
// Backpressure: none; expected words are queued with their edge number and popped on dout_valid.
module tb_mux4_arbiter;
  localparam int W  = 8;
  localparam int HM = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [3:0]   req = 4'b0000;
  logic [W-1:0] ain = '0, bin = '0, cin = '0, din = '0;
  logic [3:0]   gnt;
  logic [1:0]   reg_sel;
  logic [W-1:0] dout;
  logic         dout_valid;
  logic         busy;

  always #5 clk = ~clk;

  mux4_arbiter #(.WIDTH(W), .HOLD_MAX(HM)) dut (
    .clk(clk), .rst_n(rst_n), .req(req),
    .Ain(ain), .Bin(bin), .Cin(cin), .Din(din),
    .gnt(gnt), .reg_sel(reg_sel), .dout(dout),
    .dout_valid(dout_valid), .busy(busy)
  );

  typedef struct { int edge_no; logic [W-1:0] dat; } exp_t;
  exp_t exp_q[$];

  int n_cmp = 0;
  int n_err = 0;
  int mon_edge = 0;

  // Reference model: owner index (-1 = idle), rotation start, words sent by current owner.
  int m_owner = -1;
  int m_rr = 0;
  int m_sent = 0;
  int m_sel = 0;
  bit m_known = 0;
  bit m_in_rst = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Next requester from the rotation point, ignoring 'skip'; fixed build takes the lowest index.
  function automatic int pick(input logic [3:0] r, input int skip);
    pick = -1;
`ifdef MUX4_ARB_FIXED_PRIO_EN
    for (int j = 3; j >= 0; j--) if (r[j] && j != skip) pick = j;
`else
    for (int k = 3; k >= 0; k--) if (r[(m_rr + k) % 4] && ((m_rr + k) % 4) != skip) pick = (m_rr + k) % 4;
`endif
  endfunction

  function automatic void give(input int j);
    m_owner = j;
    m_sel   = j;
    m_rr    = (j + 1) % 4;
    m_sent  = 0;
  endfunction

  task automatic model_edge(input logic [3:0] r, input logic rn, input logic [W-1:0] a, b, c, d, input int edge_no);
    logic [W-1:0] dv [4];
    bit other;
    int hi;
    dv[0] = a; dv[1] = b; dv[2] = c; dv[3] = d;
    if (!rn) begin
      m_owner = -1; m_rr = 0; m_sent = 0; m_sel = 0;
      m_in_rst = 1; m_known = 1;
      return;
    end
    m_in_rst = 0;
    if (m_owner < 0) begin
      if (r != 4'b0000) give(pick(r, -1));
    end else begin
      other = 0;
      for (int j = 0; j < 4; j++) if (r[j] && j != m_owner) other = 1;
      if (!r[m_owner]) begin
        if (other) give(pick(r, m_owner));
        else m_owner = -1;
      end else begin
        exp_q.push_back('{edge_no, dv[m_owner]});
`ifdef MUX4_ARB_FIXED_PRIO_EN
        hi = -1;
        for (int j = 3; j >= 0; j--) if (r[j] && j < m_owner) hi = j;
        if (hi >= 0) give(hi);
`else
        hi = 0;
        m_sent++;
        if (m_sent >= HM && other) give(pick(r, m_owner));
`endif
      end
    end
  endtask

  task automatic check_outputs();
    logic [3:0] eg;
    eg = (m_owner < 0) ? 4'b0000 : (4'b0001 << m_owner);
    chk("gnt", gnt, eg);
    chk("reg_sel", reg_sel, m_sel);
    chk("busy", busy, (m_owner >= 0));
    if (m_in_rst) begin
      chk("rst_dout", dout, 0);
      chk("rst_dout_valid", dout_valid, 0);
    end
  endtask

  task automatic step(input logic [3:0] r, input logic rn, input logic [W-1:0] a, b, c, d);
    @(negedge clk);
    if (m_known) check_outputs();
    req = r; rst_n = rn; ain = a; bin = b; cin = c; din = d;
    model_edge(r, rn, a, b, c, d, mon_edge + 1);
  endtask

  function automatic logic [W-1:0] rnd();
    return W'($urandom);
  endfunction

  // Monitor: consume expected words as the DUT strobes them out.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      mon_edge++;
      #1;
      while (exp_q.size() > 0 && exp_q[0].edge_no < mon_edge) begin
        e = exp_q.pop_front();
        n_cmp++; n_err++;
        $display("FAIL missing_valid: no dout_valid for word %0h of edge %0d", e.dat, e.edge_no);
      end
      if (dout_valid) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL extra_valid: dout_valid with dout %0h at edge %0d, expected none", dout, mon_edge);
        end else begin
          e = exp_q.pop_front();
          chk("dout_edge", mon_edge, e.edge_no);
          chk("dout", dout, e.dat);
        end
      end
    end
  end

  initial begin
    logic [3:0] r;
    // Reset held with every requester asking, then A must win.
    step(4'b1111, 1'b0, 8'd1, 8'd2, 8'd3, 8'd4);
    step(4'b1111, 1'b0, 8'd1, 8'd2, 8'd3, 8'd4);
    for (int i = 0; i < 3; i++) step(4'b1111, 1'b1, rnd(), rnd(), rnd(), rnd());
    step(4'b0000, 1'b0, 0, 0, 0, 0);
    // Single requester C streaming then releasing.
    for (int i = 0; i < 4; i++) step(4'b0100, 1'b1, 0, 0, 8'd181, 0);
    for (int i = 0; i < 2; i++) step(4'b0000, 1'b1, 0, 0, 8'd181, 0);
    step(4'b0000, 1'b0, 0, 0, 0, 0);
    // A and B contend: HOLD_MAX words each, alternating with no gap.
    for (int i = 0; i < 14; i++) step(4'b0011, 1'b1, 8'd122, 8'd4, 0, 0);
    step(4'b0000, 1'b0, 0, 0, 0, 0);
    // D releases while only A waits: wrap to A.
    for (int i = 0; i < 3; i++) step(4'b1000, 1'b1, 0, 0, 0, 8'd39);
    for (int i = 0; i < 3; i++) step(4'b0001, 1'b1, rnd(), 0, 0, 8'd39);
    step(4'b0000, 1'b0, 0, 0, 0, 0);
    // Reset while D owns the bus, then D is granted again.
    for (int i = 0; i < 2; i++) step(4'b1000, 1'b1, 0, 0, 0, rnd());
    step(4'b1000, 1'b0, 0, 0, 0, rnd());
    for (int i = 0; i < 6; i++) step(4'b1000, 1'b1, 0, 0, 0, rnd());
`ifdef MUX4_ARB_FIXED_PRIO_EN
    step(4'b0000, 1'b0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(4'b0100, 1'b1, rnd(), rnd(), rnd(), rnd());
    for (int i = 0; i < 3; i++) step(4'b0101, 1'b1, rnd(), rnd(), rnd(), rnd());
    for (int i = 0; i < 3; i++) step(4'b1101, 1'b1, rnd(), rnd(), rnd(), rnd());
`endif
    // Random traffic: each line toggles occasionally, rare resets.
    r = 4'b0000;
    for (int i = 0; i < 3000; i++) begin
      for (int j = 0; j < 4; j++) if ($urandom_range(3) == 0) r[j] = ~r[j];
      step(r, ($urandom_range(63) != 0), rnd(), rnd(), rnd(), rnd());
    end
    for (int i = 0; i < 4; i++) step(4'b0000, 1'b1, 0, 0, 0, 0);
    @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mux4_arbiter.md
Name: mux4_arbiter

Overview:
- Round-robin arbiter that shares one 4:1 8-bit selection datapath between four requesters (A..D).
- Generates the 2-bit select and a one-hot grant, and registers the selected word onto a single output with a valid strobe.
- Sits in front of the CPU's shared internal bus, where requesters today drive the mux select directly; this block replaces that direct drive.

Parameters:
- WIDTH, 8, data width of each input and of dout.
- HOLD_MAX, 4, maximum consecutive transfers granted to one owner while another requester is pending (must be >=1).

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst_n  input  1  synchronous reset, active-low.
- req  input  4  request lines; req[0]=A .. req[3]=D; a requester holds its line high while it has words to send.
- Ain  input  WIDTH  requester A data; must be valid whenever req[0] is high.
- Bin  input  WIDTH  requester B data.
- Cin  input  WIDTH  requester C data.
- Din  input  WIDTH  requester D data.
- gnt  output  4  one-hot registered grant; all zeros when idle.
- reg_sel  output  2  encoded index of current owner; drives the shared mux.
- dout  output  WIDTH  registered transferred word.
- dout_valid  output  1  high for exactly the cycle after each transfer.
- busy  output  1  high whenever gnt is nonzero.

Behaviour:
- Reset (rst_n low at a clock edge): gnt=0, reg_sel=0, dout=0, dout_valid=0, busy=0, state=IDLE, rr pointer=0, hold count=0. Reset has priority over all other events.
- Transfer condition: a word transfers on any edge where gnt[i]=1 and req[i]=1. At that edge dout <= data of input i and dout_valid <= 1. On every other edge dout_valid <= 0 and dout holds its value.
- Latency:
  - req rising in IDLE -> gnt at the next edge (1 cycle).
  - Transfer -> dout/dout_valid 1 cycle later.
  - Throughput is 1 word/cycle while the owner keeps req high.
- Selection: search for a requester starting at the rr pointer and moving upward modulo 4, skipping the current owner when it is being preempted. On every grant, rr pointer <= owner index + 1 (wraps 3 -> 0).
- State IDLE (gnt=0):
  - If any req is high, go to GRANT with the selected owner and hold count = 0.
  - Otherwise stay in IDLE.
- State GRANT with owner i:
  - req[i] low (owner released, no transfer): if any other req is high, grant the next requester at this edge with no idle bubble; else go to IDLE with gnt=0.
  - Transfer while hold count == HOLD_MAX-1 and another req is pending: switch to the next requester and reset hold count to 0.
  - Transfer otherwise: hold count increments and saturates at HOLD_MAX-1; the owner keeps the grant if nothing else is pending.
- reg_sel always equals the index of the set gnt bit. reg_sel holds its last value while idle (0 after reset).
- Requester obligations: a requester must not drop req in the same cycle it expects a final transfer. Every cycle with gnt[i]&req[i] counts as a transfer.
- Simultaneous requests from idle after reset: A wins (pointer=0). Subsequent grants rotate fairly.

Optional Feature:
- Macro: MUX4_ARB_FIXED_PRIO_EN.
- When defined:
  - Fixed priority A>B>C>D replaces round-robin; the rr pointer is unused.
  - HOLD_MAX is ignored.
  - On each transfer edge, if a higher-priority req is high, the grant moves to the highest-priority pending requester.
  - Lower-priority requests never preempt.
- When undefined: round-robin with HOLD_MAX preemption, as described above.

Test Plan:
- Reset: rst_n=0 for 2 cycles with req=4'b1111 -> gnt=0, reg_sel=0, dout=0, dout_valid=0. After release, gnt=4'b0001 one cycle later.
- Single requester: req=4'b0100, Cin=181 held 3 cycles, then dropped -> gnt=4'b0100, reg_sel=2, dout=181 with dout_valid high for 3 consecutive cycles, then gnt=0 and busy=0.
- Preemption: req=4'b0011, Ain=122, Bin=4, both held, HOLD_MAX=4 -> 4 transfers of 122, then gnt=4'b0010 with 4 transfers of 4, then back to A. No idle cycles between owners.
- Wrap-around: owner D (Din=39) releases while req=4'b0001 -> gnt=4'b0001 at the next edge, reg_sel=0, dout=... (next Ain value) with no gap.
- Reset mid-operation: rst_n=0 while gnt=4'b1000 -> next edge gnt=0, dout_valid=0. After release, req=4'b1000 regrants D with hold count=0.
- With MUX4_ARB_FIXED_PRIO_EN: owner C streaming, req[0] rises -> gnt moves to 4'b0001 at the first transfer edge after req[0] is sampled high. Then req[3] rising while A streams causes no change.
